// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  logic [PW-1:0] w_slot [N];
  logic [N-1:0]  w_hit;

  // w_hit[k] is the request of the client k positions after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign w_slot[gi] = PW'((int'(i_ptr) + gi) % N);
    assign w_hit[gi]  = i_req[w_slot[gi]];
  end

  always_comb begin
    o_found = |w_hit;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) o_idx = w_slot[k];
    end
    o_gnt = '0;
    if (o_found) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter among NUM_REQ clients.
// Define UART_ARB_LOCK_EN to add req_last and keep a client granted across a multi-byte message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_transmit,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active,
  output logic                 timeout_err
);

  localparam int PW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(BUSY_TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(BUSY_TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  byte_t              r_tx_data;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [PW-1:0]      w_pick_idx;
  logic               w_pick_found;
  logic               w_accept;
  logic               w_timeout;
  byte_t              w_req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign w_req_byte[gi] = req_data[8*gi +: 8];
  end

`ifdef UART_ARB_LOCK_EN
  logic               r_locked;
  logic [NUM_REQ-1:0] r_lock_mask;

  assign w_mask = r_locked ? r_lock_mask : '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked    <= 1'b0;
      r_lock_mask <= '0;
    end else if (w_accept) begin
      r_locked    <= ~|(req_last & w_pick_gnt);
      r_lock_mask <= w_pick_gnt;
    end else if (w_timeout) begin
      r_locked    <= 1'b0;
    end
  end
`else
  assign w_mask = '1;
`endif

  assign w_req = req_valid & w_mask;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Handshake is suppressed while reset is high so no client sees a byte accepted that is then lost.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    tx_transmit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset && !tx_busy && w_pick_found) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        tx_transmit  = 1'b1;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_next = WAIT_DONE;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_accept) begin
        r_tx_data <= w_req_byte[w_pick_idx];
        r_grant   <= w_pick_gnt;
        r_ptr     <= (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
      end
      // Counter saturates at the timeout value rather than wrapping.
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT_BUSY && !tx_busy && r_cnt != TIMEOUT_CNT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout || (r_state == WAIT_DONE && !tx_busy)) begin
        r_grant <= '0;
      end
    end
  end

  assign req_ready   = w_accept ? w_pick_gnt : '0;
  assign tx_data     = r_tx_data;
  assign grant       = r_grant;
  assign active      = (r_state != IDLE);
  assign timeout_err = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model of acceptance order and timing,
// a stub transmitter serialising each strobed byte onto txd, directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_transmit;
  logic           tx_busy;
  logic           active;
  logic           timeout_err;
  logic           stub_busy = 1'b0;
  logic           ext_busy = 1'b0;
  logic           txd = 1'b1;

  assign tx_busy = stub_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_transmit (tx_transmit),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .active      (active),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one byte in flight at a time; its lifetime follows from the stub's timing.
  logic       m_inflight = 1'b0;
  int         m_acc = 0, m_free = 0, m_w = 0, m_ptr = 0;
  logic [7:0] m_byte = '0, m_last_byte = '0;
  logic       m_never = 1'b0;
  int         m_lat = 0, m_per = 1;
  logic       m_locked = 1'b0;
  int         m_lock_id = 0;
  int         cfg_never = 0, cfg_lat = 0, cfg_per = 2;

  logic [N-1:0] acc_mask = '0;
  int           acc_log[$];
  int           to_gap[$];
  int           last_strobe = 0;
  logic [7:0]   exp_rx_q[$];
  logic [N-1:0] mon_elig;
  int           mon_w;

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (m_inflight && cyc >= m_free) m_inflight = 1'b0;
      if (m_inflight) begin
        chk("busy_req_ready", req_ready, 0);
        chk("busy_active", active, 1);
        chk("busy_grant", grant, 32'd1 << m_w);
        chk("tx_transmit", tx_transmit, cyc == m_acc + 1);
        chk("timeout_err", timeout_err, m_never && (cyc == m_acc + 18));
        chk("busy_tx_data", tx_data, m_byte);
      end else begin
        mon_w = -1;
        if (!reset && !tx_busy) begin
          mon_elig = m_locked ? (req_valid & (N'(1) << m_lock_id)) : req_valid;
          mon_w = model_pick(mon_elig, m_ptr);
        end
        chk("req_ready", req_ready, (mon_w >= 0) ? (32'd1 << mon_w) : 32'd0);
        chk("idle_active", active, 0);
        chk("idle_grant", grant, 0);
        chk("idle_strobe", tx_transmit, 0);
        chk("idle_timeout", timeout_err, 0);
        chk("idle_tx_data", tx_data, m_last_byte);
        if (mon_w >= 0) begin
          m_inflight  = 1'b1;
          m_acc       = cyc;
          m_w         = mon_w;
          m_byte      = req_data[8*mon_w +: 8];
          m_last_byte = m_byte;
          m_ptr       = (mon_w + 1) % N;
          m_never     = (cfg_never >= 0) ? (cfg_never != 0) : ($urandom_range(0, 7) == 0);
          m_lat       = (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(0, 3));
          m_per       = (cfg_per >= 0) ? cfg_per : int'($urandom_range(1, 3));
          m_free      = m_never ? cyc + 19 : cyc + 3 + m_lat + 10 * m_per;
`ifdef UART_ARB_LOCK_EN
          m_locked    = !req_last[mon_w] && !m_never;
          m_lock_id   = mon_w;
`endif
          if (!m_never) exp_rx_q.push_back(m_byte);
          $display("accept client %0d byte %02h cycle %0d %s", mon_w, m_byte, cyc,
                   m_never ? "(no busy)" : "");
        end
      end
      if (tx_transmit) last_strobe = cyc;
      if (timeout_err) to_gap.push_back(cyc - last_strobe);
      acc_mask = req_ready;
      for (int k = 0; k < N; k++) if (req_ready[k]) acc_log.push_back(k);
      if (reset) begin
        m_inflight  = 1'b0;
        m_ptr       = 0;
        m_last_byte = '0;
        m_locked    = 1'b0;
      end
    end
  end

  // Stub transmitter: busy rises lat cycles after the strobe, then a 10-bit frame at per cycles/bit.
  task automatic stub_send(input logic [7:0] b, input int lat, input int per);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    repeat (lat) @(posedge clk);
    @(posedge clk); #1;
    stub_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      txd = frame[k];
      repeat (per) @(posedge clk);
      #1;
    end
    stub_busy = 1'b0;
    txd = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx_transmit && !m_never) stub_send(tx_data, m_lat, m_per);
    end
  end

  logic rx_samples[$];
  logic [7:0] rx_byte;
  int rx_per;
  initial begin
    forever begin
      @(negedge clk);
      if (stub_busy) begin
        rx_samples.push_back(txd);
      end else if (rx_samples.size() > 0) begin
        rx_per = rx_samples.size() / 10;
        for (int b = 0; b < 8; b++) rx_byte[b] = rx_samples[(b + 1) * rx_per];
        chk("txd_start", rx_samples[0], 0);
        chk("txd_stop", rx_samples[9 * rx_per], 1);
        if (exp_rx_q.size() == 0) chk("txd_unexpected", 1, 0);
        else chk("txd_byte", rx_byte, exp_rx_q.pop_front());
        rx_samples.delete();
      end
    end
  end

  task automatic wait_log(input string tag, input int n, input int budget);
    int i = 0;
    @(negedge clk); #1;
    while (acc_log.size() < n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk(tag, acc_log.size() >= n, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    req_valid = '0;
    @(negedge clk); #1;
    while ((active || tx_busy) && i < 600) begin
      @(negedge clk); #1;
      i++;
    end
    chk(tag, {30'd0, active, tx_busy}, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int log_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_transmit", tx_transmit, 0);
    chk("rst_active", active, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk); #1;

    // Single byte 0x32 from client 0
    acc_log.delete();
    req_data[7:0] = 8'h32;
    req_valid = 4'b0001;
    wait_log("t1_accept", 1, 50);
    req_valid = '0;
    drain("t1_drain");
    chk("t1_count", acc_log.size(), 1);
    chk("t1_client", log_at(0), 0);

    // All four held valid: fair rotation
    do_reset();
    acc_log.delete();
    cfg_lat = -1; cfg_per = -1;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    wait_log("t2_accepts", 5, 1000);
    req_valid = '0;
    drain("t2_drain");
    for (int i = 0; i < 5; i++) chk("t2_order", log_at(i), i % 4);

    // Transmitter never raises busy: timeout then next client served
    acc_log.delete();
    to_gap.delete();
    cfg_never = 1;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    wait_log("t3_accept", 1, 50);
    cfg_never = 0;
    req_data[31:24] = 8'hC3;
    req_valid = 4'b1000;
    wait_log("t3_next", 2, 100);
    req_valid = '0;
    drain("t3_drain");
    chk("t3_gap", (to_gap.size() > 0) ? to_gap[0] : -1, 17);
    chk("t3_next_client", log_at(1), 3);

    // Reset in WAIT_DONE
    cfg_lat = 0; cfg_per = 2;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int i = 0; i < 60 && !tx_busy; i++) @(negedge clk);
    chk("t4_busy_seen", tx_busy, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc_log.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_active", active, 0);
    chk("t4_grant", grant, 0);
    chk("t4_tx_data", tx_data, 0);
    chk("t4_strobe", tx_transmit, 0);
    @(posedge clk); #1;
    wait_log("t4_accept", 1, 100);
    chk("t4_ptr_restart", log_at(0), 0);
    req_valid = '0;
    drain("t4_drain");

    // External busy blocks grant
    acc_log.delete();
    ext_busy = 1'b1;
    req_data[23:16] = 8'h77;
    req_valid = 4'b0100;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_blocked", acc_log.size(), 0);
    ext_busy = 1'b0;
    wait_log("t5_accept", 1, 10);
    chk("t5_client", log_at(0), 2);
    req_valid = '0;
    drain("t5_drain");

`ifdef UART_ARB_LOCK_EN
    // Locked multi-byte message from client 1 while client 0 stays valid
    do_reset();
    acc_log.delete();
    c1 = 0;
    req_data[7:0] = 8'h10;  req_last[0] = 1'b1;
    req_data[15:8] = 8'h21; req_last[1] = 1'b0;
    req_valid = 4'b0011;
    for (int n = 1; n <= 5; n++) begin
      wait_log("t6_accept", n, 300);
      if (log_at(n - 1) == 1) begin
        c1++;
        req_data[15:8] = 8'(8'h21 + c1);
        req_last[1] = (c1 == 2);
        if (c1 == 3) req_valid[1] = 1'b0;
      end
    end
    req_valid = '0;
    drain("t6_drain");
    chk("t6_order0", log_at(0), 0);
    chk("t6_order1", log_at(1), 1);
    chk("t6_order2", log_at(2), 1);
    chk("t6_order3", log_at(3), 1);
    chk("t6_order4", log_at(4), 0);
`endif

    // Random traffic against the model
    do_reset();
    cfg_never = -1; cfg_lat = -1; cfg_per = -1;
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < N; k++) begin
        if (acc_mask[k]) begin
          req_valid[k] = 1'($urandom_range(0, 1));
          req_data[8*k +: 8] = 8'($urandom);
          req_last[k] = 1'($urandom_range(0, 1));
        end else if (!req_valid[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[k] = 1'b1;
            req_data[8*k +: 8] = 8'($urandom);
            req_last[k] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    drain("rand_drain");
    repeat (3) @(posedge clk);
    chk("rx_queue_empty", exp_rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter among NUM_REQ byte-producing clients.
- Per-client valid/ready byte handshake; round-robin selection of the next client.
- Presents the chosen byte to the transmitter and issues a single-cycle transmit strobe.
- Tracks the transmitter busy flag through rise and fall, so only one byte is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
BUSY_TIMEOUT, 16, max clk cycles after the transmit strobe for tx_busy to rise before abort

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  client i has a byte pending
req_data  input  8*NUM_REQ  client i byte on bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot; byte of client i accepted this cycle
tx_data  output  8  byte to transmitter data input
tx_transmit  output  1  one-cycle start strobe to transmitter
tx_busy  input  1  transmitter busy flag
grant  output  NUM_REQ  one-hot owner of the in-flight byte; 0 when idle
active  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse when a busy timeout aborts a byte

Behaviour:
- Reset: clk is the only clock. reset is synchronous and active-high.
  - State goes to IDLE.
  - Outputs clear: tx_transmit=0, tx_data=0, grant=0, req_ready=0, active=0, timeout_err=0.
  - Round-robin pointer goes to 0; timeout counter clears.
  - Reset asserted mid-transfer wins over every other event. No strobe is issued the cycle after reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant requires any req_valid AND tx_busy=0.
  - Winner = first valid index at or above ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] is high combinationally in that cycle; the handshake completes on that clk edge.
  - On that edge: req_data of the winner is latched into tx_data, grant <= onehot(winner), ptr <= (winner+1) mod NUM_REQ, state -> ISSUE.
  - If tx_busy=1 in IDLE, nothing is granted.
- ISSUE:
  - tx_transmit=1 for exactly this one cycle.
  - Next state -> WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. If the counter reaches BUSY_TIMEOUT while tx_busy=0: timeout_err pulses for 1 cycle and state -> IDLE. The byte is dropped, not retried.
- WAIT_DONE:
  - tx_busy=0 -> IDLE; grant clears on that edge.
  - No timeout applies; duration is set by the baud rate.
- tx_data is held stable from ISSUE until the next grant.
- req_ready is never high outside IDLE, and at most one bit is set.
- Minimum spacing between accepted bytes is 3 + busy-high duration cycles.
- Counter width: $clog2(BUSY_TIMEOUT+1). The counter saturates and never wraps.
- A client that drops req_valid before acceptance is simply not selected. Clients must hold req_data stable while req_valid is high.

Optional Feature:
Macro: UART_ARB_LOCK_EN.
- Defined:
  - Adds input req_last [NUM_REQ], sampled together with the accepted byte.
  - While the locked client's accepted byte had req_last=0, IDLE grants only that client, regardless of ptr; other clients wait.
  - A byte with req_last=1 releases the lock, and ptr advances normally.
  - A timeout also releases the lock.
- Undefined: port absent; every byte is arbitrated independently.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum typedef (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - byte_t typedef (8 bits);
  - localparam-style function for the counter width.
- Sub-module rr_arbiter (parameter N): combinational round-robin pick from req and ptr. Outputs a one-hot grant and a found flag. Reused for lock-mode masking.

Test Plan:
1. Reset, then req_valid=4'b0001, req_data[7:0]=8'h32, driving a real transmitter at 100 MHz / 9600 baud:
   - req_ready[0] pulses once;
   - ISSUE occurs the next cycle, with tx_transmit high for 1 cycle and tx_data=8'h32;
   - txd serialises 0x32;
   - active falls one cycle after busy falls.
2. All four valid with bytes 8'hA0..8'hA3, held:
   - accept order is 0,1,2,3,0;
   - tx_data sequence is A0,A1,A2,A3,A0;
   - never two strobes inside one busy window.
3. Behavioural transmitter stub that never raises busy, BUSY_TIMEOUT=16:
   - timeout_err pulses exactly 17 cycles after the strobe;
   - FSM returns to IDLE;
   - next valid client is served.
4. Reset asserted during WAIT_DONE:
   - next cycle all outputs are 0 and the state is IDLE;
   - no tx_transmit follows;
   - ptr restarts at client 0.
5. tx_busy held high externally with req_valid=4'b0100: no req_ready until busy falls, then client 2 is accepted.
6. With UART_ARB_LOCK_EN: client 1 sends 3 bytes (req_last=0,0,1) while client 0 is continuously valid:
   - all client-1 bytes go out consecutively;
   - then client 0 is granted.
